imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate sign-extender.
- Takes a full 32-bit instruction plus an immediate-type select and produces an XLEN-wide immediate one cycle after acceptance.
- Adds shift-amount and CSR-zimm modes, an illegal-mode flag and a tag that travels with each result.
- Sits between decode and the register-read/execute stage. Both sides use a valid/ready handshake backed by a 2-entry output buffer.

---
 rtl/imm_gen_pipe.sv | 89 ++++++++
 tb/tb_imm_gen_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry output FIFO.
// Immediates are extended at accept time and stored with their tag and illegal flag.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_source,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immediate,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0]  imm_new;
  logic             illegal_new;
  logic [XLEN-1:0]  mem_imm [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic [1:0]       mem_ill;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;
  logic             head_sel;
  logic             unused_opcode;

  // The opcode field plays no part in immediate formation.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm_new     = '0;
    illegal_new = 1'b0;
    case (imm_source)
      3'b000: imm_new = XLEN'($signed(instr[31:20]));
      3'b001: imm_new = XLEN'($signed({instr[31:25], instr[11:7]}));
      3'b010: imm_new = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      3'b011: imm_new = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      3'b100: imm_new = XLEN'($signed({instr[31:12], 12'b0}));
      3'b101: begin
        if (XLEN == 64) imm_new = XLEN'(instr[25:20]);
        else            imm_new = XLEN'(instr[24:20]);
      end
      3'b110: imm_new = XLEN'(instr[19:15]);
      default: illegal_new = 1'b1;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_imm[0] <= '0;
      mem_imm[1] <= '0;
      mem_tag[0] <= '0;
      mem_tag[1] <= '0;
      mem_ill    <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= imm_new;
        mem_tag[wr_ptr] <= in_tag;
        mem_ill[wr_ptr] <= illegal_new;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // When empty, rd_ptr has already moved past the last delivered slot, so
  // looking one slot back keeps the outputs holding their last value.
  assign head_sel    = (count == 2'd0) ? ~rd_ptr : rd_ptr;
  assign immediate   = mem_imm[head_sel];
  assign out_tag     = mem_tag[head_sel];
  assign out_illegal = mem_ill[head_sel];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and
// are checked against a queue-based arithmetic reference model.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [3:0]  tag;
    logic        ill;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_source;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [3:0]  tag32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [3:0]  tag64;

  int     tests;
  int     fails;
  entry_t q[$];
  entry_t last;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_source(imm_source), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .immediate(imm32),
    .out_tag(tag32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_source(imm_source), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .immediate(imm64),
    .out_tag(tag64), .out_illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sx(input longint u, input int bits);
    if (u >= (longint'(1) << (bits - 1))) return u - (longint'(1) << bits);
    return u;
  endfunction

  // Value of the immediate as a number, then truncated to the datapath width.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    longint v;
    case (src)
      3'd0: v = sx(longint'(ins[31:20]), 12);
      3'd1: v = sx(longint'({ins[31:25], ins[11:7]}), 12);
      3'd2: v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * 2;
      3'd3: v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * 2;
      3'd4: v = sx(longint'(ins[31:12]), 20) * 4096;
      3'd5: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_output();
    entry_t head;
    head = (q.size() != 0) ? q[0] : last;
    check("in_ready32", 64'(in_ready32), 64'(q.size() != 2));
    check("in_ready64", 64'(in_ready64), 64'(q.size() != 2));
    check("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
    check("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
    check("imm32", 64'(imm32), head.i32);
    check("imm64", imm64, head.i64);
    check("tag32", 64'(tag32), 64'(head.tag));
    check("tag64", 64'(tag64), 64'(head.tag));
    check("ill32", 64'(ill32), 64'(head.ill));
    check("ill64", 64'(ill64), 64'(head.ill));
  endtask

  // One clock: drive inputs, check, advance the model across the rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src,
                      input logic [3:0] tg, input logic ordy);
    bit     room;
    bit     pop_it;
    entry_t e;
    in_valid   = v;
    instr      = ins;
    imm_source = src;
    in_tag     = tg;
    out_ready  = ordy;
    #1;
    check_output();
    room   = (q.size() < 2);
    pop_it = (q.size() != 0) && ordy;
    e.i32  = ref_imm(ins, src, 32);
    e.i64  = ref_imm(ins, src, 64);
    e.tag  = tg;
    e.ill  = (src == 3'd7);
    @(posedge clk);
    if (pop_it) last = q.pop_front();
    if (v && room) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clear_model();
    q.delete();
    last.i32 = '0;
    last.i64 = '0;
    last.tag = '0;
    last.ill = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_model();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    instr      = 'x;
    imm_source = 3'd0;
    in_tag     = 4'd0;
    out_ready  = 1'b1;
    #12;
    check("rst_valid32", 64'(out_valid32), 64'd0);
    check("rst_imm64", imm64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);

    // Test 1: I-type -1.
    step(1'b1, 32'hFFF00093, 3'd0, 4'd3, 1'b1);
    check("t1_imm32", 64'(imm32), 64'hFFFFFFFF);
    check("t1_tag", 64'(tag32), 64'd3);

    // Test 2: branch then LUI back to back.
    step(1'b1, 32'hFE000EE3, 3'd2, 4'd1, 1'b1);
    check("t2_b_imm32", 64'(imm32), 64'hFFFFFFFC);
    step(1'b1, 32'h123450B7, 3'd4, 4'd2, 1'b1);
    check("t2_u_imm32", 64'(imm32), 64'h12345000);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);

    // Test 3: 64-bit LUI sign extension and 6-bit shamt.
    step(1'b1, 32'h800000B7, 3'd4, 4'd4, 1'b1);
    check("t3_u_imm64", imm64, 64'hFFFFFFFF80000000);
    step(1'b1, 32'h03F01013, 3'd5, 4'd6, 1'b1);
    check("t3_sh_imm64", imm64, 64'h000000000000003F);
    check("t3_sh_imm32", 64'(imm32), 64'h000000000000001F);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);

    // Test 4: backpressure with three offered entries.
    step(1'b1, 32'h00100093, 3'd0, 4'd1, 1'b0);
    step(1'b1, 32'h00200093, 3'd0, 4'd2, 1'b0);
    step(1'b1, 32'h00300093, 3'd0, 4'd3, 1'b0);
    check("t4_full", 64'(in_ready32), 64'd0);
    step(1'b1, 32'hABCDE0B7, 3'd0, 4'd3, 1'b0);
    step(1'b1, 32'h00300093, 3'd0, 4'd3, 1'b1);
    step(1'b1, 32'h00300093, 3'd0, 4'd3, 1'b1);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);

    // Test 5: illegal select and CSR zimm.
    step(1'b1, 32'hFFFFFFFF, 3'd7, 4'd5, 1'b1);
    check("t5_ill", 64'(ill32), 64'd1);
    check("t5_imm", 64'(imm32), 64'd0);
    step(1'b1, 32'h000FD073, 3'd6, 4'd7, 1'b1);
    check("t5_zimm", 64'(imm32), 64'h1F);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);

    // Test 6: asynchronous reset with a full buffer.
    step(1'b1, 32'h7FF00093, 3'd0, 4'd8, 1'b0);
    step(1'b1, 32'h80000093, 3'd0, 4'd9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async32", 64'(out_valid32), 64'd0);
    check("t6_async64", 64'(out_valid64), 64'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hFFF00093, 3'd0, 4'd10, 1'b1);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);

    // Random traffic; instr is left undriven whenever in_valid is low.
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [31:0] ins;
      v   = 1'($urandom_range(0, 1));
      ins = v ? 32'($urandom) : 'x;
      step(v, ins, 3'($urandom_range(0, 7)), 4'($urandom), ($urandom_range(0, 3) != 0));
    end
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
